program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
- REQ-001: Parameter DEPTH, default 16: number of program-memory words loaded per session.
- REQ-002: Parameter ADD_WIDTH, default 4: program-memory address width.
- REQ-003: Parameter WIDTH, default 32: instruction word width, fixed at 4 bytes.
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: rst  input  1  synchronous, active-low reset.
- REQ-006: load_en  input  1  level request to load a program; deassertion aborts the session.
- REQ-007: byte_valid  input  1  byte_data holds a valid byte.
- REQ-008: byte_data  input  8  program byte, little-endian within each word.
- REQ-009: byte_ready  output  1  loader can accept a byte this cycle.
- REQ-010: mem_wen  output  1  one-cycle program-memory write strobe.
- REQ-011: mem_addr  output  ADD_WIDTH  program-memory write address.
- REQ-012: mem_wdata  output  WIDTH  assembled instruction word.
- REQ-013: cpu_hold  output  1  high while loading, to hold the CPU pipeline.
- REQ-014: done  output  1  full program loaded, and checksum passed when checked.
- REQ-015: err  output  1  checksum mismatch.

Function
- REQ-016: The FSM SHALL have states IDLE, LOAD, WRITE, CHECK and DONE.
- REQ-017: A byte is accepted only on a rising edge where byte_valid=1 and byte_ready=1.
- REQ-018: byte_ready=1 only in LOAD and CHECK; it is 0 in all other states.
- REQ-019: IDLE with load_en=1 -> LOAD; mem_addr=0 and the byte counter is 0.
- REQ-020: In LOAD, accepted byte k (k=0..3) is placed in mem_wdata[8k+7:8k].
- REQ-021: After the 4th byte is accepted, the next state is WRITE.
- REQ-022: In WRITE, mem_wen=1 for exactly one cycle, with stable mem_addr/mem_wdata; no byte is accepted.
- REQ-023: WRITE at mem_addr<DEPTH-1 -> LOAD; mem_addr increments by 1 and the byte counter clears.
- REQ-024: WRITE at mem_addr=DEPTH-1 -> CHECK when the macro is defined, otherwise -> DONE; mem_addr holds (no wrap).
- REQ-025: First byte to mem_wen latency is 5 cycles minimum; byte_valid gaps stall without data loss.
- REQ-026: cpu_hold=1 in LOAD, WRITE and CHECK; 0 in IDLE and DONE.
- REQ-027: done=1 only in DONE with err=0; done is held until DONE -> IDLE.
- REQ-028: DONE with load_en=0 -> IDLE; done and err clear.
- REQ-029: load_en=0 in LOAD, WRITE or CHECK -> IDLE next cycle; partial word discarded, no mem_wen, mem_addr=0. This abort takes priority over a same-cycle byte acceptance or write.
- REQ-030: mem_wen is never asserted outside WRITE.

Reset
- REQ-031: rst=0 at a rising edge -> IDLE; mem_addr=0, mem_wdata=0, byte counter=0, checksum=0.
- REQ-032: Output values under reset: mem_wen=0, byte_ready=0, cpu_hold=0, done=0, err=0.
- REQ-033: Reset mid-session has the same effect as REQ-031; no partial write occurs.

Configuration
- REQ-034: Macro PROGRAM_LOADER_CHECKSUM_EN.
- REQ-035: Defined: an 8-bit modulo-256 sum of all accepted program bytes is kept. CHECK accepts one trailing byte, then -> DONE. If that byte equals the sum: done=1, err=0. Otherwise: err=1, done=0.
- REQ-036: Undefined: no CHECK state and no checksum logic; err is tied 0.

Verification
- REQ-037: Load 64 bytes, byte i = i (0x00..0x3F), byte_valid continuous -> 16 mem_wen pulses; addr 0 data 0x03020100, addr 15 data 0x3F3E3D3C; done=1; cpu_hold=0 after the last write.
- REQ-038: Same load with byte_valid high every 3rd cycle -> identical write data and addresses; no mem_wen while fewer than 4 bytes of a word are accepted.
- REQ-039: Drop load_en after 6 bytes -> 1 write (addr 0), then IDLE, mem_addr=0, cpu_hold=0. A reload gives addr 0 = first 4 new bytes.
- REQ-040: Pull rst low in the WRITE cycle of word 7 -> the next cycle shows all REQ-032 values; no further mem_wen.
- REQ-041: With the macro defined, send 64 bytes of 0x01, then trailer 0x40 -> done=1, err=0. With trailer 0x41 -> err=1, done=0.
- REQ-042: Hold load_en=1 in DONE -> no restart and no mem_wen. Drop load_en -> IDLE. Reassert it -> a new session starts at addr 0.

Source files
------------

// File: rtl/program_loader.sv
// Byte-serial program loader: packs little-endian bytes into WIDTH-bit words and writes DEPTH words.
// Optional trailing checksum byte verification is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int DEPTH     = 16,
    parameter int ADD_WIDTH = 4,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 mem_wen,
    output logic [ADD_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

    localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [ADD_WIDTH-1:0] addr_d;
    logic [WIDTH-1:0]     wdata_d;
    logic                 wen_q;
    logic                 accept;
    logic                 err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]           sum_q, sum_d;
    logic                 err_q;
`endif

    assign accept = byte_valid && byte_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`else
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (!load_en) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = byte_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + byte_data;
`endif
                    if (cnt_q == 2'd3) begin
                        state_d = WRITE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                if (!load_en) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else if (mem_addr == LAST_ADDR) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = LOAD;
                    addr_d  = mem_addr + 1'b1;
                    cnt_d   = '0;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (!load_en) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    err_d   = (byte_data != sum_q);
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (!load_en) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wen_q      <= 1'b0;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            wen_q      <= (state_d == WRITE);
            done       <= (state_d == DONE) && !err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            byte_ready <= (state_d == LOAD) || (state_d == CHECK);
            cpu_hold   <= (state_d == LOAD) || (state_d == WRITE) || (state_d == CHECK);
            sum_q      <= sum_d;
            err_q      <= err_d;
`else
            byte_ready <= (state_d == LOAD);
            cpu_hold   <= (state_d == LOAD) || (state_d == WRITE);
`endif
        end
    end

    // A same-cycle abort must suppress the write strobe, so load_en gates the registered pulse.
    assign mem_wen = wen_q && load_en;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
